// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared types for the K&S processor.
//   decoded_instruction_type : IR decode produced by data_path
//   ctrl_state_type          : control_unit FSM states
//   ALU_*                    : ALU operation encodings driven on `operation`
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE,
    I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
    I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    S_FETCH, S_LOAD_IR, S_DECODE, S_LOAD_ADDR, S_LOAD_WB,
    S_STORE, S_EXEC, S_BRANCH, S_NEXT, S_HALT
  } ctrl_state_type;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

endpackage

// File: rtl/control_unit.sv
// control_unit: instruction-sequencing FSM for the K&S processor.
// Drives every control input of data_path from its own state, the decoded
// instruction and the registered flags.
//   clk, rst_n            : clock / async active-low reset
//   decoded_instruction   : IR decode from data_path
//   zero_op, neg_op,
//   unsigned_overflow,
//   signed_overflow       : registered flags from data_path
//   branch, pc_enable     : PC source select / PC update strobe
//   ir_enable             : IR capture strobe
//   addr_sel              : 1 = RAM address from PC, 0 = from IR address field
//   c_sel                 : 1 = reg write data from RAM, 0 = from ALU
//   operation             : ALU op
//   write_reg_enable,
//   flags_reg_enable,
//   ram_write_enable      : write strobes
//   halt                  : processor stopped
module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  ctrl_state_type state_q, state_d;
  logic           branch_cond;

  // Branching never looks at unsigned overflow.
  logic unused_uov;
  assign unused_uov = unsigned_overflow;

  // State register. Outputs are decoded from state_q, so asserting reset
  // drops every strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:   state_d = S_LOAD_IR;
      S_LOAD_IR: state_d = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:                            state_d = S_LOAD_ADDR;
          I_STORE:                           state_d = S_STORE;
          I_ADD, I_SUB, I_AND, I_OR, I_MOVE: state_d = S_EXEC;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:            state_d = S_BRANCH;
          I_HALT:                            state_d = S_HALT;
          default:                           state_d = S_NEXT;
        endcase
      end
      S_LOAD_ADDR: state_d = S_LOAD_WB;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Branch condition, evaluated on the flags registered by the previous
  // instruction's execute cycle.
  always_comb begin
    branch_cond = 1'b0;
    case (decoded_instruction)
      I_BRANCH: branch_cond = 1'b1;
      I_BZERO:  branch_cond = zero_op;
      I_BNZERO: branch_cond = !zero_op;
      I_BNEG:   branch_cond = neg_op;
      I_BNNEG:  branch_cond = !neg_op;
      I_BOV:    branch_cond = signed_overflow;
      I_BNOV:   branch_cond = !signed_overflow;
      default:  branch_cond = 1'b0;
    endcase
  end

  assign branch = (state_q == S_BRANCH) && branch_cond;

  // Output decode
  always_comb begin
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_ADD;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    unique case (state_q)
      S_FETCH:   addr_sel = 1'b1;
      S_LOAD_IR: begin
        addr_sel  = 1'b1;
        ir_enable = 1'b1;
      end
      S_LOAD_WB: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        pc_enable        = 1'b1;
      end
      S_STORE: begin
        ram_write_enable = 1'b1;
        pc_enable        = 1'b1;
      end
      S_EXEC: begin
        write_reg_enable = 1'b1;
        pc_enable        = 1'b1;
        case (decoded_instruction)
          I_ADD:  begin operation = ALU_ADD; flags_reg_enable = 1'b1; end
          I_AND:  begin operation = ALU_AND; flags_reg_enable = 1'b1; end
          I_OR:   begin operation = ALU_OR;  flags_reg_enable = 1'b1; end
          I_SUB:  begin operation = ALU_SUB; flags_reg_enable = 1'b1; end
          // MOVE passes a through the ALU as a|a and leaves flags alone.
          I_MOVE: operation = ALU_OR;
          default: ;
        endcase
      end
      S_BRANCH, S_NEXT: pc_enable = 1'b1;
      S_HALT:           halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for control_unit. A per-instruction model
// expands each instruction into its expected per-cycle output vectors; one
// compare process checks the DUT against them every cycle, and a few literal
// checks pin specific cycles.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  decoded_instruction_type di = I_NOP;
  logic zero_op = 0, neg_op = 0, uov = 0, sov = 0;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable;
  logic flags_reg_enable, ram_write_enable, halt;
  logic [1:0] operation;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(di),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov),
    .signed_overflow(sov), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .ram_write_enable(ram_write_enable),
    .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic br, pc, ir, as, cs;
    logic [1:0] op;
    logic wr, fl, rw, h;
  } out_t;

  typedef struct {
    out_t  o;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  out_t act;

  assign act = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                write_reg_enable, flags_reg_enable, ram_write_enable, halt};

  function automatic out_t mk(bit br, bit pc, bit ir, bit as, bit cs,
                              logic [1:0] op, bit wr, bit fl, bit rw, bit h);
    return {br, pc, ir, as, cs, op, wr, fl, rw, h};
  endfunction

  task automatic chk(input string name, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, a, e);
    end
  endtask

  task automatic push(input out_t o, input string tag);
    exp_t e;
    e.o = o;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Compare process: one expected vector per cycle while any are queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, 16'(act), 16'(e.o));
    end
  end

  // Model: expand an instruction into its per-cycle output vectors.
  // Called at the start of the fetch cycle.
  task automatic begin_instr(input decoded_instruction_type i, input bit fz,
                             input bit fn, input bit fv, input bit fu,
                             output int ncyc);
    string t;
    bit    taken;
    logic [1:0] op;
    t = i.name();
    di = i; zero_op = fz; neg_op = fn; sov = fv; uov = fu;
    push(mk(0,0,0,1,0,2'd0,0,0,0,0), {t, " fetch"});
    push(mk(0,0,1,1,0,2'd0,0,0,0,0), {t, " load_ir"});
    push(mk(0,0,0,0,0,2'd0,0,0,0,0), {t, " decode"});
    ncyc = 4;
    case (i)
      I_LOAD: begin
        push(mk(0,0,0,0,0,2'd0,0,0,0,0), {t, " addr"});
        push(mk(0,1,0,0,1,2'd0,1,0,0,0), {t, " wb"});
        ncyc = 5;
      end
      I_STORE: push(mk(0,1,0,0,0,2'd0,0,0,1,0), {t, " store"});
      I_ADD, I_AND, I_OR, I_SUB, I_MOVE: begin
        op = (i == I_ADD) ? 2'd0 : (i == I_AND) ? 2'd1 : (i == I_SUB) ? 2'd3 : 2'd2;
        push(mk(0,1,0,0,0,op,1,(i != I_MOVE),0,0), {t, " exec"});
      end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
        case (i)
          I_BZERO:  taken = fz;
          I_BNZERO: taken = !fz;
          I_BNEG:   taken = fn;
          I_BNNEG:  taken = !fn;
          I_BOV:    taken = fv;
          I_BNOV:   taken = !fv;
          default:  taken = 1'b1;
        endcase
        push(mk(taken,1,0,0,0,2'd0,0,0,0,0), {t, " branch"});
      end
      I_HALT: ncyc = 3;
      default: push(mk(0,1,0,0,0,2'd0,0,0,0,0), {t, " next"});
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input decoded_instruction_type i, input bit fz,
                           input bit fn, input bit fv, input bit fu);
    int n;
    begin_instr(i, fz, fn, fv, fu, n);
    repeat (n) step();
  endtask

  decoded_instruction_type br_list[7] = '{I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
                                          I_BNNEG, I_BOV, I_BNOV};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit p, x;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset addr_sel", 16'(addr_sel), 16'd1);
    chk("reset others", 16'(act & ~mk(0,0,0,1,0,2'd0,0,0,0,0)), 16'd0);
    rst_n = 1'b1;

    // ADD with literal pins on cycles 0..3
    begin_instr(I_ADD, 0, 0, 0, 0, n);
    chk("c0 addr_sel", 16'(addr_sel), 16'd1);
    step();
    chk("c1 ir_enable", 16'(ir_enable), 16'd1);
    step();
    chk("c2 ir_enable", 16'(ir_enable), 16'd0);
    step();
    chk("add exec", 16'({operation, write_reg_enable, flags_reg_enable, pc_enable, c_sel}),
        16'b00_1_1_1_0);
    step();

    // MOVE literal pin
    begin_instr(I_MOVE, 1, 1, 1, 1, n);
    repeat (3) step();
    chk("move exec", 16'({operation, flags_reg_enable, write_reg_enable}), 16'b10_0_1);
    step();

    run_instr(I_SUB, 0, 1, 0, 1);
    run_instr(I_AND, 1, 0, 1, 0);
    run_instr(I_OR,  0, 0, 1, 1);

    // LOAD: literal pin on the write-back cycle
    begin_instr(I_LOAD, 0, 0, 0, 0, n);
    repeat (4) step();
    chk("load wb", 16'({c_sel, write_reg_enable, addr_sel}), 16'b1_1_0);
    step();

    run_instr(I_STORE, 0, 0, 0, 0);
    run_instr(I_NOP, 1, 1, 1, 1);

    // All branch types, both polarities; unrelated flags driven opposite.
    foreach (br_list[k]) begin
      for (int pol = 0; pol < 2; pol++) begin
        p = pol[0];
        x = !p;
        case (br_list[k])
          I_BZERO, I_BNZERO: run_instr(br_list[k], p, x, x, x);
          I_BNEG, I_BNNEG:   run_instr(br_list[k], x, p, x, x);
          I_BOV, I_BNOV:     run_instr(br_list[k], x, x, p, x);
          default:           run_instr(br_list[k], p, p, p, p);
        endcase
      end
    end

    // BZERO literal pin: taken
    begin_instr(I_BZERO, 1, 0, 0, 0, n);
    repeat (3) step();
    chk("bzero taken", 16'({branch, pc_enable}), 16'b11);
    step();

    // Reset asserted between edges during S_EXEC
    begin_instr(I_ADD, 0, 0, 0, 0, n);
    void'(exp_q.pop_back());
    push(mk(0,0,0,1,0,2'd0,0,0,0,0), "reset in exec");
    repeat (3) step();
    #2;
    chk("pre-reset wr", 16'(write_reg_enable), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("async drop", 16'(act), 16'(mk(0,0,0,1,0,2'd0,0,0,0,0)));
    step();
    rst_n = 1'b1;
    run_instr(I_STORE, 0, 0, 0, 0);

    // HALT: reached on 4th cycle, persists 20 cycles with no strobes
    begin_instr(I_HALT, 0, 0, 0, 0, n);
    repeat (3) step();
    chk("halt lit", 16'(halt), 16'd1);
    for (int c = 0; c < 20; c++) begin
      di = (c % 2 == 0) ? I_ADD : I_NOP;
      push(mk(0,0,0,0,0,2'd0,0,0,0,1), "halt hold");
    end
    repeat (20) step();

    // Reset pulse leaves halt
    rst_n = 1'b0;
    push(mk(0,0,0,1,0,2'd0,0,0,0,0), "halt reset");
    #1;
    chk("halt cleared", 16'(halt), 16'd0);
    step();
    rst_n = 1'b1;
    run_instr(I_ADD, 0, 0, 0, 0);

    step();
    chk("queue drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing FSM for the K&S processor; drives every control input of `data_path` and reacts to its decoded instruction and registered flags. It sits beside `data_path` in the processor top and owns fetch/decode/execute timing, branch resolution and the RAM write strobe. It is purely control: it holds no datapath state beyond its own FSM register.

## Interface
- Parameters: none.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `decoded_instruction` in `decoded_instruction_type`: current IR decode from `data_path`.
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow` in 1 each: registered flags from `data_path`.
- `branch` out 1: PC loads the instruction address field instead of PC+1.
- `pc_enable` out 1: PC update strobe.
- `ir_enable` out 1: IR captures `data_in`.
- `addr_sel` out 1: 1 = RAM address from PC, 0 = from instruction address field.
- `c_sel` out 1: 1 = register write data from RAM, 0 = from ALU.
- `operation` out 2: ALU op; 00 add, 01 and, 10 or, 11 sub.
- `write_reg_enable` out 1: register-file write strobe.
- `flags_reg_enable` out 1: flag-register update strobe.
- `ram_write_enable` out 1: RAM write strobe; write data is `data_out`.
- `halt` out 1: processor stopped.

## Operation
- RAM is synchronous-read: `data_in` is valid the cycle after the address is presented.
- All outputs are Moore functions of state, except `branch`, which is combinational on state and flags in S_BRANCH. Any output not listed for a state is 0.
- S_FETCH: `addr_sel`=1. Next state is S_LOAD_IR.
- S_LOAD_IR: `addr_sel`=1, `ir_enable`=1. Next state is S_DECODE.
- S_DECODE: no strobes. Dispatches on `decoded_instruction`:
  - LOAD goes to S_LOAD_ADDR.
  - STORE goes to S_STORE.
  - ADD/SUB/AND/OR/MOVE go to S_EXEC.
  - The seven branch types go to S_BRANCH.
  - HALT goes to S_HALT.
  - NOP and any unlisted value go to S_NEXT.
- S_LOAD_ADDR: `addr_sel`=0. Next state is S_LOAD_WB.
- S_LOAD_WB: `addr_sel`=0, `c_sel`=1, `write_reg_enable`=1, `pc_enable`=1. Next state is S_FETCH.
- S_STORE: `addr_sel`=0, `ram_write_enable`=1, `pc_enable`=1. Next state is S_FETCH.
- S_EXEC: `c_sel`=0, `write_reg_enable`=1, `pc_enable`=1. Next state is S_FETCH.
  - `operation` is ADD 00, AND 01, OR 10, SUB 11, MOVE 10 (a|a = a).
  - `flags_reg_enable`=1 for ADD/SUB/AND/OR; 0 for MOVE.
- S_BRANCH: `pc_enable`=1. Next state is S_FETCH. `branch`=1 when:
  - BRANCH: always.
  - BZERO: `zero_op`. BNZERO: !`zero_op`.
  - BNEG: `neg_op`. BNNEG: !`neg_op`.
  - BOV: `signed_overflow`. BNOV: !`signed_overflow`.
  - `unsigned_overflow` is unused by branching.
- S_NEXT: `pc_enable`=1. Next state is S_FETCH.
- S_HALT: `halt`=1, all strobes 0. Stays in S_HALT until reset.

## Timing
- Reset (async assert, sync release) forces S_FETCH. Output values in reset: `addr_sel`=1, all others 0, `operation`=00.
- Cycles per instruction:
  - ALU/MOVE/STORE/branch/NOP: 4.
  - LOAD: 5.
  - HALT: 3 cycles to reach S_HALT.
- Flags written in S_EXEC are visible to the branch in the next instruction's S_BRANCH. No hazard exists because at least 3 cycles separate them.
- `decoded_instruction` is sampled only in S_DECODE and S_EXEC/S_BRANCH. Its value in other states is don't-care.
- Reset mid-instruction aborts it immediately. No partial strobe may follow the deassertion of `rst_n`.
- Strobes are single-cycle per instruction. No state asserts `pc_enable` twice per instruction.

## Structure
- `k_and_s_pkg` gains `ctrl_state_type` (enum of the states above) and ALU op constants `ALU_ADD`/`ALU_AND`/`ALU_OR`/`ALU_SUB`.
- `decoded_instruction_type` is reused unchanged.
- Single module. Internal blocks:
  - state register;
  - next-state combinational block;
  - output decode;
  - branch-condition logic.
- No sub-module.

## Test plan
- Reset, then release: cycle 0 in S_FETCH with `addr_sel`=1; `ir_enable`=1 exactly on cycle 1; no other strobe for 3 cycles.
- ADD decoded: strobes in the 4th cycle are `operation`=00, `write_reg_enable`=1, `flags_reg_enable`=1, `pc_enable`=1, `c_sel`=0. MOVE gives `operation`=10 and `flags_reg_enable`=0.
- LOAD: `addr_sel`=0 for 2 cycles; `c_sel`=1 and `write_reg_enable`=1 only in the 5th cycle. STORE: `ram_write_enable`=1 for exactly 1 cycle with `addr_sel`=0.
- BZERO with `zero_op`=1 gives `branch`=1 and `pc_enable`=1; with `zero_op`=0 gives `branch`=0 and `pc_enable`=1. Repeat for all 7 branch types, both flag polarities (14 cases).
- HALT: `halt`=1 from the 4th cycle onward and persists for 20 cycles with zero strobes; `rst_n` pulse returns to S_FETCH.
- Assert `rst_n`=0 during S_EXEC between clock edges: all strobes drop asynchronously; no register write occurs.
